uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` serializer between `NumReq` byte-stream requesters, such as CPU MMIO and a debug/trace port. It accepts one byte at a time from a granted requester over a valid/ready handshake and issues a single-cycle `write` to `uart_tx`. It holds `write_data` stable for the whole frame, because `uart_tx` samples the data bits serially, and releases only once `uart_tx` reports ready again. Multi-byte messages can lock the grant so bytes from different requesters never interleave.

## Interface
- `NumReq`, default 2: number of requesters, 1..8.
- `DataBitsSize`, default 8: byte width; must match `uart_tx`.
- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NumReq: per-requester byte valid.
- `req_data`  in  NumReq*DataBitsSize: flattened bytes; requester i is in bits [i*DataBitsSize +: DataBitsSize].
- `req_last`  in  NumReq: byte ends a message; 0 keeps the grant locked.
- `req_ready`  out  NumReq: one-hot accept; a byte transfers when valid & ready.
- `tx_write`  out  1: one-cycle write strobe to `uart_tx`.
- `tx_write_data`  out  DataBitsSize: held byte to `uart_tx`.
- `tx_write_ready`  in  1: `uart_tx` write_ready.
- `busy`  out  1: state != IDLE.
- `grant_id`  out  max(1,$clog2(NumReq)): index of the last accepted requester.
- `locked`  out  1: a message is in progress; only `grant_id` may be accepted.

## Operation
- Reset values:
  - All outputs are 0.
  - Round-robin pointer is 0.
  - State is IDLE.
- State machine:
  - IDLE: if `tx_write_ready` and a candidate is valid, assert `req_ready[w]` combinationally, latch the byte into `tx_write_data`, set `grant_id=w`, and go to SEND. Otherwise stay in IDLE.
  - SEND: `tx_write=1` for exactly this cycle, then go to WAIT_LOW.
  - WAIT_LOW: stay until `tx_write_ready==0`, then go to WAIT_DONE.
  - WAIT_DONE: stay until `tx_write_ready==1`, then go to IDLE.
- Candidates:
  - When `locked`, the only candidate is `grant_id`; other requesters' valid is ignored.
  - Otherwise, all requesters are candidates. The winner is the first valid index searching from the pointer upward, modulo NumReq.
- Lock update on acceptance:
  - `locked <= !req_last[w]`.
  - If `req_last[w]`, the pointer becomes (w+1) mod NumReq; otherwise the pointer is unchanged.
- `tx_write_data` changes only on acceptance; it is constant from SEND through WAIT_DONE.
- If the locked owner deasserts valid, the block waits in IDLE indefinitely. There is no timeout.
- Behaviour is undefined if a requester changes `req_data` or `req_last` while valid and not ready; the bench must not do this.
- Reset mid-frame:
  - All registers clear and the state returns to IDLE.
  - `uart_tx` is not reset by this block. No new byte is accepted until `tx_write_ready` is 1.

## Timing
- Cycle A: `req_ready` high, byte accepted.
- Cycle A+1: `tx_write=1`.
- Cycle A+2: `tx_write_ready` is low (registered in `uart_tx`).
- The next acceptance happens no earlier than the first IDLE cycle after `tx_write_ready` returns high. This cycle is the first IDLE cycle, one cycle after WAIT_DONE observes `tx_write_ready=1`.
- Throughput is one byte per `uart_tx` frame plus 2 cycles of overhead.
- `req_ready` is combinational from `req_valid`, `tx_write_ready`, state, and the pointer. There is no combinational path from `req_ready` back to `req_valid`.
- At most one `req_ready` bit is high in any cycle, and only in IDLE.

## Structure
- Shared package `uart_pkg`:
  - `uart_arb_state_e` enum: IDLE=0, SEND=1, WAIT_LOW=2, WAIT_DONE=3.
  - A localparam helper for the `grant_id` width: max(1,$clog2(NumReq)).
- Sub-module `uart_rr_pick`: purely combinational.
  - Inputs: request mask and pointer.
  - Outputs: `found` and winner index.
  - Instantiated once; the mask is `req_valid` when unlocked, or only the `grant_id` bit when locked.

## Test plan
- Bench setup: `uart_tx` with ClockFreqHz=10, BaudRate=1.
- Single byte: req0 sends 0xA5 with last=1.
  - `req_ready[0]` pulses 1 cycle.
  - `tx_write` pulses the next cycle with 0xA5, and `tx_write_data` holds 0xA5 until `tx_write_ready` rises.
  - `tx_sig` decodes as 0xA5, LSB first.
- Fairness: req0=0x11 and req1=0x22, both continuously valid with last=1.
  - Transmitted order is 11,22,11,22.
  - `grant_id` alternates 0,1,0,1.
- Lock: req1 sends 01,02,03 (last on 03) while req0 holds 0x55 valid.
  - Order is 01,02,03,55.
  - `locked` is high from the acceptance of 01 until the acceptance of 03.
- Owner gap: req1 is locked after 0x01, then drops valid for 50 cycles while req0 is valid.
  - `req_ready[0]` stays 0.
  - req1 resumes with 0x02 (last) and it is sent next.
- Backpressure: the bench holds `tx_write_ready=0` with req0 valid.
  - `req_ready` stays 0 and `tx_write` stays 0.
  - Releasing `tx_write_ready` gives acceptance in the same cycle.
- Reset mid-frame: assert `rst` for 1 cycle during WAIT_DONE.
  - The next cycle has all outputs 0 and state IDLE.
  - A pending req0 byte is not accepted until `tx_write_ready` is 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

    // Arbiter sequencing states; the encoding is visible on debug probes.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_DONE = 2'd3
    } uart_arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or above the
// pointer, wrapping modulo NumReq.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter  int NumReq = 2,
    localparam int IdW    = id_width(NumReq)
) (
    input  logic [NumReq-1:0] i_mask,
    input  logic [IdW-1:0]    i_ptr,
    output logic              o_found,
    output logic [IdW-1:0]    o_idx
);

    // w_rot_idx[k] is the requester examined k-th, i.e. (ptr + k) mod NumReq.
    logic [IdW-1:0]    w_rot_idx [NumReq];
    logic [NumReq-1:0] w_rot_hit;

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_rot
        logic [IdW:0] w_sum;
        assign w_sum          = {1'b0, i_ptr} + (IdW+1)'(gi);
        assign w_rot_idx[gi]  = (w_sum >= (IdW+1)'(NumReq))
                              ? IdW'(w_sum - (IdW+1)'(NumReq))
                              : w_sum[IdW-1:0];
        assign w_rot_hit[gi]  = i_mask[w_rot_idx[gi]];
    end

    // Lowest rotated position wins; scanning downward lets it overwrite.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (w_rot_hit[k]) begin
                o_found = 1'b1;
                o_idx   = w_rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between several byte streams,
// with message locking so multi-byte messages never interleave.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NumReq       = 2,
    parameter  int DataBitsSize = 8,
    localparam int IdW          = id_width(NumReq)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NumReq-1:0]              req_valid,
    input  logic [NumReq*DataBitsSize-1:0] req_data,
    input  logic [NumReq-1:0]              req_last,
    output logic [NumReq-1:0]              req_ready,
    output logic                           tx_write,
    output logic [DataBitsSize-1:0]        tx_write_data,
    input  logic                           tx_write_ready,
    output logic                           busy,
    output logic [IdW-1:0]                 grant_id,
    output logic                           locked
);

    uart_arb_state_e         r_state;
    uart_arb_state_e         w_state_next;
    logic [IdW-1:0]          r_ptr;
    logic [IdW-1:0]          r_grant_id;
    logic                    r_locked;
    logic [DataBitsSize-1:0] r_tx_data;

    logic [DataBitsSize-1:0] w_req_bytes [NumReq];
    logic [NumReq-1:0]       w_owner_mask;
    logic [NumReq-1:0]       w_pick_mask;
    logic                    w_found;
    logic [IdW-1:0]          w_pick_idx;
    logic [IdW-1:0]          w_ptr_next;
    logic                    w_accept;

    // Unpack the flattened byte bus and build the owner's one-hot mask.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
        assign w_req_bytes[gi]  = req_data[gi*DataBitsSize +: DataBitsSize];
        assign w_owner_mask[gi] = (r_grant_id == IdW'(gi));
    end

    // While a message is open only its owner may compete.
    assign w_pick_mask = r_locked ? (req_valid & w_owner_mask) : req_valid;

    uart_rr_pick #(
        .NumReq (NumReq)
    ) u_pick (
        .i_mask  (w_pick_mask),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    assign w_ptr_next = (w_pick_idx == IdW'(NumReq - 1)) ? '0 : w_pick_idx + IdW'(1);

    // Next-state and handshake decode; acceptance only from IDLE with the
    // serializer ready, and never while reset is being applied.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        req_ready    = '0;
        case (r_state)
            IDLE: begin
                if (tx_write_ready && w_found && !rst) begin
                    w_accept     = 1'b1;
                    req_ready    = NumReq'(1) << w_pick_idx;
                    w_state_next = SEND;
                end
            end
            SEND:      w_state_next = WAIT_LOW;
            WAIT_LOW:  if (!tx_write_ready) w_state_next = WAIT_DONE;
            WAIT_DONE: if (tx_write_ready)  w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture byte, owner and lock on acceptance; the byte then stays put
    // for the whole frame because uart_tx shifts it out bit by bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_locked   <= 1'b0;
            r_ptr      <= '0;
        end else if (w_accept) begin
            r_tx_data  <= w_req_bytes[w_pick_idx];
            r_grant_id <= w_pick_idx;
            r_locked   <= !req_last[w_pick_idx];
            if (req_last[w_pick_idx]) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign tx_write      = (r_state == SEND);
    assign tx_write_data = r_tx_data;
    assign busy          = (r_state != IDLE);
    assign grant_id      = r_grant_id;
    assign locked        = r_locked;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx stand-in.
module tb_uart_tx_arbiter;

    localparam int NR    = 2;
    localparam int DW    = 8;
    localparam int IW    = 1;
    localparam int FRAME = 100;   // 10 clocks per bit, start + 8 data + stop

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0] req_last  = '0;
    logic [NR-1:0] req_ready;
    logic          tx_write;
    logic [DW-1:0] tx_write_data;
    logic          tx_write_ready;
    logic          busy;
    logic [IW-1:0] grant_id;
    logic          locked;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NumReq       (NR),
        .DataBitsSize (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .tx_write       (tx_write),
        .tx_write_data  (tx_write_data),
        .tx_write_ready (tx_write_ready),
        .busy           (busy),
        .grant_id       (grant_id),
        .locked         (locked)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // uart_tx stand-in: busy for FRAME cycles after a write, ready registered.
    int   u_cnt   = 0;
    logic bp_hold = 1'b0;
    assign tx_write_ready = (u_cnt == 0) && !bp_hold;
    always @(posedge clk) begin
        if (tx_write === 1'b1) u_cnt <= FRAME;
        else if (u_cnt != 0)   u_cnt <= u_cnt - 1;
    end

    // Per-requester byte sources: {last, data}.
    logic [8:0]    src_mem [NR][64];
    int            src_wr [NR] = '{default: 0};
    int            src_rd [NR] = '{default: 0};
    logic [NR-1:0] gap     = '0;
    logic [NR-1:0] acc_vec = '0;

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_mem[r][src_wr[r]] = {l, d};
        src_wr[r]++;
    endtask

    function automatic bit drained();
        for (int i = 0; i < NR; i++) if (src_rd[i] != src_wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Source driver: pop accepted bytes, present the next one.
    initial begin
        forever begin
            @(posedge clk); #2;
            for (int i = 0; i < NR; i++) begin
                if (acc_vec[i]) src_rd[i]++;
                if (src_rd[i] < src_wr[i] && !gap[i]) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*DW +: DW] = src_mem[i][src_rd[i]][7:0];
                    req_last[i]          = src_mem[i][src_rd[i]][8];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Reference model: free / write-due / waiting-for-frame, plus arbitration rules.
    bit         m_free = 1'b1, m_write_due = 1'b0, m_waiting = 1'b0, m_saw_low = 1'b0;
    bit         m_locked = 1'b0;
    int         m_ptr = 0, m_grant = 0;
    logic [7:0] m_data = '0;
    int         seen_rdy0 = 0, seen_any_rdy = 0, seen_wr = 0;

    typedef struct { logic [7:0] b; int g; logic l; } log_t;
    log_t log_q[$];

    initial begin : monitor
        int            win;
        logic [NR-1:0] exp_rdy;
        log_t          e;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_free = 1'b1; m_write_due = 1'b0; m_waiting = 1'b0; m_saw_low = 1'b0;
                m_locked = 1'b0; m_ptr = 0; m_grant = 0; m_data = '0;
                acc_vec = '0;
            end else begin
                win = -1;
                exp_rdy = '0;
                if (m_free && tx_write_ready === 1'b1) begin
                    if (m_locked) begin
                        if (req_valid[m_grant]) win = m_grant;
                    end else begin
                        for (int k = 0; k < NR; k++)
                            if (win < 0 && req_valid[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
                    end
                end
                if (win >= 0) exp_rdy[win] = 1'b1;
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                chk("tx_write", 32'(tx_write), 32'(m_write_due));
                chk("busy", 32'(busy), 32'(!m_free));
                chk("grant_id", 32'(grant_id), 32'(m_grant));
                chk("locked", 32'(locked), 32'(m_locked));
                chk("tx_write_data", 32'(tx_write_data), 32'(m_data));
                seen_rdy0    += (req_ready[0] === 1'b1) ? 1 : 0;
                seen_any_rdy += (req_ready !== '0) ? 1 : 0;
                seen_wr      += (tx_write === 1'b1) ? 1 : 0;
                if (tx_write === 1'b1) begin
                    e.b = tx_write_data; e.g = int'(grant_id); e.l = locked;
                    log_q.push_back(e);
                    $display("tx byte %02h from req %0d locked=%0b at %0t", e.b, e.g, e.l, $time);
                end
                acc_vec = req_valid & req_ready;
                if (m_write_due) begin
                    m_write_due = 1'b0; m_waiting = 1'b1; m_saw_low = 1'b0;
                end else if (m_waiting) begin
                    if (!m_saw_low) begin
                        if (tx_write_ready !== 1'b1) m_saw_low = 1'b1;
                    end else if (tx_write_ready === 1'b1) begin
                        m_waiting = 1'b0; m_free = 1'b1;
                    end
                end else if (win >= 0) begin
                    m_free = 1'b0; m_write_due = 1'b1;
                    m_data = req_data[win*DW +: DW];
                    m_grant = win;
                    m_locked = !req_last[win];
                    if (req_last[win]) m_ptr = (win + 1) % NR;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (!(drained() && m_free && u_cnt == 0 && !bp_hold) && c < 5000) begin
            step(); c++;
        end
        if (c >= 5000) begin
            n_checks++; n_errors++;
            $display("FAIL %s timeout: not idle after %0d cycles", tag, c);
        end
    endtask

    task automatic wait_log(input int n, input string tag);
        int c = 0;
        while (log_q.size() < n && c < 2000) begin step(); c++; end
        if (c >= 2000) begin
            n_checks++; n_errors++;
            $display("FAIL %s timeout: log size %0d required %0d", tag, log_q.size(), n);
        end
    endtask

    task automatic wait_free(input string tag);
        int c = 0;
        while (!(m_free && tx_write_ready === 1'b1) && c < 2000) begin step(); c++; end
        if (c >= 2000) begin
            n_checks++; n_errors++;
            $display("FAIL %s timeout: arbiter not free", tag);
        end
    endtask

    typedef struct {
        int grp; int src; logic [7:0] data; logic last;
        logic [7:0] exp_byte; int exp_grant; logic exp_locked;
    } vec_t;
    vec_t vecs [9];

    initial begin : main
        int base, cnt, idx;
        int st [NR];
        int nb [NR];

        // group 0 fairness, group 1 single byte, group 2 locked message
        vecs[0] = '{0, 0, 8'h11, 1'b1, 8'h11, 0, 1'b0};
        vecs[1] = '{0, 1, 8'h22, 1'b1, 8'h22, 1, 1'b0};
        vecs[2] = '{0, 0, 8'h11, 1'b1, 8'h11, 0, 1'b0};
        vecs[3] = '{0, 1, 8'h22, 1'b1, 8'h22, 1, 1'b0};
        vecs[4] = '{1, 0, 8'hA5, 1'b1, 8'hA5, 0, 1'b0};
        vecs[5] = '{2, 1, 8'h01, 1'b0, 8'h01, 1, 1'b1};
        vecs[6] = '{2, 1, 8'h02, 1'b0, 8'h02, 1, 1'b1};
        vecs[7] = '{2, 1, 8'h03, 1'b1, 8'h03, 1, 1'b0};
        vecs[8] = '{2, 0, 8'h55, 1'b1, 8'h55, 0, 1'b0};

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_tx_write", 32'(tx_write), 32'h0);
        chk("rst_tx_data", 32'(tx_write_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);

        // Table-driven groups
        for (int g = 0; g < 3; g++) begin
            base = log_q.size();
            cnt  = 0;
            step();
            for (int v = 0; v < 9; v++)
                if (vecs[v].grp == g) push(vecs[v].src, vecs[v].data, vecs[v].last);
            wait_idle("vec_group");
            for (int v = 0; v < 9; v++) begin
                if (vecs[v].grp == g) begin
                    if (base + cnt < log_q.size()) begin
                        chk("vec_byte", 32'(log_q[base+cnt].b), 32'(vecs[v].exp_byte));
                        chk("vec_grant", 32'(log_q[base+cnt].g), 32'(vecs[v].exp_grant));
                        chk("vec_locked", 32'(log_q[base+cnt].l), 32'(vecs[v].exp_locked));
                    end else begin
                        n_checks++; n_errors++;
                        $display("FAIL vec_missing: entry %0d of group %0d not sent", cnt, g);
                    end
                    cnt++;
                end
            end
            chk("vec_count", 32'(log_q.size() - base), 32'(cnt));
        end

        // Owner gap: req1 locked, req0 waiting must be ignored
        base = log_q.size();
        push(1, 8'h01, 1'b0);
        wait_log(base + 1, "gap_first");
        wait_free("gap_free");
        push(0, 8'h77, 1'b1);
        seen_rdy0 = 0;
        repeat (50) step();
        chk("gap_rdy0", 32'(seen_rdy0), 32'h0);
        push(1, 8'h02, 1'b1);
        wait_idle("gap_done");
        if (log_q.size() == base + 3) begin
            chk("gap_b0", 32'(log_q[base].b), 32'h01);
            chk("gap_b1", 32'(log_q[base+1].b), 32'h02);
            chk("gap_b2", 32'(log_q[base+2].b), 32'h77);
        end else chk("gap_count", 32'(log_q.size() - base), 32'd3);

        // Backpressure from the serializer
        base = log_q.size();
        bp_hold = 1'b1;
        push(0, 8'h3C, 1'b1);
        seen_any_rdy = 0; seen_wr = 0;
        repeat (20) step();
        chk("bp_ready_held", 32'(seen_any_rdy), 32'h0);
        chk("bp_write_held", 32'(seen_wr), 32'h0);
        bp_hold = 1'b0;
        @(negedge clk);
        chk("bp_release_rdy", 32'(req_ready), 32'h1);
        wait_idle("bp_done");
        chk("bp_byte", 32'((log_q.size() > base) ? log_q[base].b : 8'h00), 32'h3C);

        // Reset during WAIT_DONE
        base = log_q.size();
        push(1, 8'hC3, 1'b0);
        wait_log(base + 1, "rst_first");
        repeat (5) step();
        push(0, 8'h5A, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_tx_write", 32'(tx_write), 32'h0);
        chk("mid_rst_tx_data", 32'(tx_write_data), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_grant", 32'(grant_id), 32'h0);
        chk("mid_rst_locked", 32'(locked), 32'h0);
        wait_idle("rst_done");
        if (log_q.size() == base + 2) begin
            chk("rst_next_byte", 32'(log_q[base+1].b), 32'h5A);
            chk("rst_next_grant", 32'(log_q[base+1].g), 32'h0);
        end else chk("rst_count", 32'(log_q.size() - base), 32'd2);

        // Randomized traffic checked cycle by cycle and by per-source order
        base = log_q.size();
        for (int i = 0; i < NR; i++) begin
            st[i] = src_wr[i];
            nb[i] = $urandom_range(10, 14);
            for (int j = 0; j < nb[i]; j++)
                push(i, 8'($urandom), (j == nb[i] - 1) ? 1'b1 : ($urandom_range(0, 2) == 0));
        end
        for (int c = 0; c < 8000 && !drained(); c++) begin
            step();
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 7) == 0) gap[i] = ~gap[i];
            if ($urandom_range(0, 15) == 0) bp_hold = ~bp_hold;
        end
        gap = '0;
        bp_hold = 1'b0;
        wait_idle("rand_done");
        for (int i = 0; i < NR; i++) begin
            idx = 0;
            for (int k = base; k < log_q.size(); k++) begin
                if (log_q[k].g == i) begin
                    if (idx < nb[i]) chk("rand_order", 32'(log_q[k].b), 32'(src_mem[i][st[i]+idx][7:0]));
                    idx++;
                end
            end
            chk("rand_count", 32'(idx), 32'(nb[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
